// File: rtl/load_store_unit.sv
// Load/store unit: sequences one core load or store through a ready/valid data-memory port,
// handling lane alignment, byte enables, sign/zero extension and a bounded wait for mem_ready.
module load_store_unit #(
  parameter int unsigned N       = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  input  logic         req_write,
  input  logic [2:0]   funct3,
  input  logic [N-1:0] addr,
  input  logic [N-1:0] wdata,
  output logic         stall,
  output logic [N-1:0] rdata_out,
  output logic         done,
  output logic         err,
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  output logic [3:0]   mem_be,
  input  logic         mem_ready,
  input  logic [N-1:0] mem_rdata
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned BE_W  = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [2:0]       f3_q, f3_d;
  logic [1:0]       off_q, off_d;
  logic [N-1:0]     rdata_q, rdata_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [N-1:0]     mem_addr_q, mem_addr_d;
  logic [N-1:0]     mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]  mem_be_q, mem_be_d;

  logic             illegal_c;
  logic             misaligned_c;
  logic [BE_W-1:0]  be_c;
  logic [N-1:0]     wdata_rep_c;
  logic [7:0]       byte_c;
  logic [15:0]      half_c;
  logic [N-1:0]     load_c;

  // Request decode: legality, alignment, lane enables and replicated store data.
  always_comb begin
    illegal_c    = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (funct3[2] && req_write);
    misaligned_c = 1'b0;
    be_c         = 4'b1111;
    wdata_rep_c  = wdata;
    case (funct3[1:0])
      2'b00: begin
        be_c        = 4'b0001 << addr[1:0];
        wdata_rep_c = {4{wdata[7:0]}};
      end
      2'b01: begin
        misaligned_c = addr[0];
        be_c         = 4'b0011 << addr[1:0];
        wdata_rep_c  = {2{wdata[15:0]}};
      end
      default: misaligned_c = (addr[1:0] != 2'b00);
    endcase
  end

  // Load extraction from the returned word using the latched offset and access type.
  always_comb begin
    byte_c = mem_rdata[{off_q, 3'b000} +: 8];
    half_c = mem_rdata[{off_q[1], 4'b0000} +: 16];
    case (f3_q[1:0])
      2'b00:   load_c = {{(N-8){byte_c[7] & ~f3_q[2]}}, byte_c};
      2'b01:   load_c = {{(N-16){half_c[15] & ~f3_q[2]}}, half_c};
      default: load_c = mem_rdata;
    endcase
  end

  // Reset counts as IDLE so the core is held while reset is asserted with a request pending.
  assign stall = req_valid & (rst | (state_q != S_DONE));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    f3_d        = f3_q;
    off_d       = off_q;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (illegal_c || misaligned_c) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d     = S_BUSY;
            cnt_d       = '0;
            we_d        = req_write;
            f3_d        = funct3;
            off_d       = addr[1:0];
            mem_addr_d  = {addr[N-1:2], 2'b00};
            mem_wdata_d = wdata_rep_c;
            mem_be_d    = be_c;
            mem_req_d   = 1'b1;
            mem_we_d    = req_write;
          end
        end
      end
      S_BUSY: begin
        mem_req_d = 1'b1;
        mem_we_d  = we_q;
        if (mem_ready) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (!we_q) rdata_d = load_c;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          err_d     = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (!we_q) rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      f3_q        <= '0;
      off_q       <= '0;
      rdata_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
    end
  end

  assign rdata_out = rdata_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus randomized accesses against an
// arithmetic model of alignment, lane enables, extension, latency and timeout.
module tb_load_store_unit;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, done, err, mem_req, mem_we;
  logic [31:0] rdata_out, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.N(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write), .funct3(funct3),
    .addr(addr), .wdata(wdata), .stall(stall), .rdata_out(rdata_out), .done(done), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_rdata;

  // Observations of the most recent access
  int          o_lat;
  bit          o_done, o_err, o_req, o_unstable, o_stall_bad, o_done_after, o_we;
  logic [31:0] o_addr, o_wd, o_rdata;
  logic [3:0]  o_be;

  // Reference model
  function automatic bit m_err(bit we, logic [2:0] f3, logic [31:0] a);
    int sz = 1 << f3[1:0];
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (we && f3[2])) return 1'b1;
    return (a % sz) != 0;
  endfunction

  function automatic logic [3:0] m_be(logic [2:0] f3, logic [31:0] a);
    int sz  = 1 << f3[1:0];
    int off = a % 4;
    return 4'(((1 << sz) - 1) << off);
  endfunction

  function automatic logic [31:0] m_wd(logic [2:0] f3, logic [31:0] wd);
    int sz = 1 << f3[1:0];
    if (sz == 1) return (wd & 32'hFF) * 32'h01010101;
    if (sz == 2) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(logic [2:0] f3, logic [31:0] a, logic [31:0] rd);
    int sz = 1 << f3[1:0];
    logic [31:0] mask, v;
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    v = (rd >> (8 * (a % 4))) & mask;
    if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v | ~mask;
    return v;
  endfunction

  // Drives one request and records what the DUT did; comparisons live in the test tasks.
  task automatic run_access(input bit we, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rd, input int rlat);
    o_lat = -1; o_done = 0; o_err = 0; o_req = 0; o_unstable = 0; o_stall_bad = 0;
    o_done_after = 0; o_we = 0; o_addr = '0; o_wd = '0; o_be = '0; o_rdata = '0;
    req_valid = 1'b1; req_write = we; funct3 = f3; addr = a; wdata = wd; mem_rdata = rd;
    for (int c = 0; c < 200; c++) begin
      mem_ready = (rlat >= 0 && c == rlat + 1) || (c == 0 && $urandom_range(1, 0) == 1);
      #1;
      if (stall !== 1'b1) o_stall_bad = 1;
      @(posedge clk); @(negedge clk);
      if (mem_req === 1'b1) begin
        if (!o_req) begin
          o_req = 1; o_addr = mem_addr; o_be = mem_be; o_wd = mem_wdata; o_we = mem_we;
        end else if ({mem_addr, mem_be, mem_wdata, mem_we} !== {o_addr, o_be, o_wd, o_we}) begin
          o_unstable = 1;
        end
      end
      if (done === 1'b1) begin
        o_done = 1; o_lat = c + 1; o_err = err; o_rdata = rdata_out;
        break;
      end
    end
    if (o_done) begin
      mem_ready = 1'b1; mem_rdata = ~rd;
      #1;
      if (stall !== 1'b0) o_stall_bad = 1;
      @(posedge clk); @(negedge clk);
      o_done_after = done;
      if (rdata_out !== o_rdata) o_stall_bad = 1;
    end
    req_valid = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; funct3 = '0; addr = '0; wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    @(negedge clk); @(posedge clk); @(negedge clk);
    vectors++;
    if ({done, err, mem_req, mem_we, mem_be} !== 8'h00) begin
      miscompares++; $display("FAIL reset_ctrl got %b want 00000000", {done, err, mem_req, mem_we, mem_be});
    end
    vectors++;
    if ({mem_addr, mem_wdata, rdata_out} !== 96'h0) begin
      miscompares++; $display("FAIL reset_data got %h %h %h want 0", mem_addr, mem_wdata, rdata_out);
    end
    req_valid = 1'b1; #1;
    vectors++;
    if (stall !== 1'b1) begin miscompares++; $display("FAIL reset_stall got %b want 1", stall); end
    req_valid = 1'b0; #1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    exp_rdata = '0;
  endtask

  task automatic test_lw;
    run_access(1'b0, 3'b010, 32'h100, $urandom, 32'hDEADBEEF, 0);
    exp_rdata = 32'hDEADBEEF;
    vectors++;
    if (o_lat != 2 || o_err !== 1'b0) begin
      miscompares++; $display("FAIL lw_latency got lat=%0d err=%b want lat=2 err=0", o_lat, o_err);
    end
    vectors++;
    if (o_addr !== 32'h100 || o_be !== 4'b1111 || o_we !== 1'b0) begin
      miscompares++; $display("FAIL lw_port got addr=%h be=%b we=%b want 100 1111 0", o_addr, o_be, o_we);
    end
    vectors++;
    if (o_rdata !== exp_rdata) begin miscompares++; $display("FAIL lw_rdata got %h want %h", o_rdata, exp_rdata); end
    vectors++;
    if (o_stall_bad || o_done_after !== 1'b0) begin
      miscompares++; $display("FAIL lw_stall_done got stall_bad=%b done_after=%b want 0 0", o_stall_bad, o_done_after);
    end
  endtask

  task automatic test_lb_lbu;
    run_access(1'b0, 3'b000, 32'h103, $urandom, 32'h80FF7F01, 1);
    vectors++;
    if (o_be !== 4'b1000 || o_rdata !== 32'hFFFFFF80 || o_lat != 3) begin
      miscompares++; $display("FAIL lb got be=%b rdata=%h lat=%0d want 1000 ffffff80 3", o_be, o_rdata, o_lat);
    end
    run_access(1'b0, 3'b100, 32'h103, $urandom, 32'h80FF7F01, 0);
    exp_rdata = 32'h00000080;
    vectors++;
    if (o_be !== 4'b1000 || o_rdata !== exp_rdata) begin
      miscompares++; $display("FAIL lbu got be=%b rdata=%h want 1000 00000080", o_be, o_rdata);
    end
  endtask

  task automatic test_sh;
    run_access(1'b1, 3'b001, 32'h202, 32'h1234ABCD, $urandom, 1);
    vectors++;
    if (o_we !== 1'b1 || o_addr !== 32'h200 || o_be !== 4'b1100 || o_wd !== 32'hABCDABCD) begin
      miscompares++;
      $display("FAIL sh_port got we=%b addr=%h be=%b wd=%h want 1 200 1100 abcdabcd", o_we, o_addr, o_be, o_wd);
    end
    vectors++;
    if (o_rdata !== exp_rdata || o_err !== 1'b0) begin
      miscompares++; $display("FAIL sh_rdata got %h err=%b want %h err=0", o_rdata, o_err, exp_rdata);
    end
  endtask

  task automatic test_misaligned;
    logic [2:0]  f3s [7] = '{3'b010, 3'b011, 3'b110, 3'b111, 3'b100, 3'b101, 3'b001};
    bit          wes [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] as  [7] = '{32'h102, 32'h100, 32'h100, 32'h104, 32'h100, 32'h100, 32'h301};
    for (int i = 0; i < 7; i++) begin
      run_access(wes[i], f3s[i], as[i], $urandom, $urandom, 0);
      vectors++;
      if (o_req || o_lat != 1 || o_err !== 1'b1 || o_rdata !== exp_rdata) begin
        miscompares++;
        $display("FAIL err_access[%0d] got req=%b lat=%0d err=%b rdata=%h want 0 1 1 %h",
                 i, o_req, o_lat, o_err, o_rdata, exp_rdata);
      end
    end
  endtask

  task automatic test_timeout;
    run_access(1'b1, 3'b010, 32'h304, $urandom, $urandom, -1);
    vectors++;
    if (o_lat != int'(TO) + 1 || o_err !== 1'b1 || o_rdata !== exp_rdata) begin
      miscompares++; $display("FAIL sw_timeout got lat=%0d err=%b rdata=%h want %0d 1 %h", o_lat, o_err, o_rdata, TO + 1, exp_rdata);
    end
    run_access(1'b0, 3'b010, 32'h308, $urandom, 32'h5555AAAA, int'(TO) - 1);
    exp_rdata = 32'h5555AAAA;
    vectors++;
    if (o_lat != int'(TO) + 1 || o_err !== 1'b0 || o_rdata !== exp_rdata) begin
      miscompares++; $display("FAIL last_cycle_ready got lat=%0d err=%b rdata=%h want %0d 0 %h", o_lat, o_err, o_rdata, TO + 1, exp_rdata);
    end
    run_access(1'b0, 3'b010, 32'h300, $urandom, $urandom, -1);
    exp_rdata = '0;
    vectors++;
    if (o_lat != int'(TO) + 1 || o_err !== 1'b1 || o_rdata !== 32'h0 || !o_req || o_unstable) begin
      miscompares++;
      $display("FAIL lw_timeout got lat=%0d err=%b rdata=%h req=%b unstable=%b want %0d 1 0 1 0",
               o_lat, o_err, o_rdata, o_req, o_unstable, TO + 1);
    end
  endtask

  task automatic test_rst_busy;
    bit saw_done;
    run_access(1'b0, 3'b010, 32'h400, $urandom, 32'hCAFEF00D, 0);
    exp_rdata = 32'hCAFEF00D;
    req_valid = 1'b1; req_write = 1'b0; funct3 = 3'b010; addr = 32'h404; mem_ready = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    vectors++;
    if (mem_req !== 1'b1 || rdata_out !== exp_rdata) begin
      miscompares++; $display("FAIL rst_busy_pre got req=%b rdata=%h want 1 %h", mem_req, rdata_out, exp_rdata);
    end
    rst = 1'b1; #1;
    vectors++;
    if (stall !== 1'b1) begin miscompares++; $display("FAIL rst_busy_stall got %b want 1", stall); end
    @(posedge clk); @(negedge clk);
    exp_rdata = '0;
    vectors++;
    if (mem_req !== 1'b0 || rdata_out !== 32'h0 || done !== 1'b0) begin
      miscompares++; $display("FAIL rst_busy_post got req=%b rdata=%h done=%b want 0 0 0", mem_req, rdata_out, done);
    end
    rst = 1'b0; req_valid = 1'b0;
    saw_done = 0;
    repeat (20) begin
      @(posedge clk); @(negedge clk);
      if (done === 1'b1 || mem_req === 1'b1) saw_done = 1;
    end
    vectors++;
    if (saw_done) begin miscompares++; $display("FAIL rst_busy_quiet got activity=1 want 0"); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 60; i++) begin
      bit          we, e_acc;
      logic [2:0]  f3;
      logic [31:0] a, wd, rd;
      int          rlat, r, e_lat;
      bit          e_err;
      we = 1'($urandom_range(1, 0)); f3 = 3'($urandom_range(7, 0));
      a = $urandom; wd = $urandom; rd = $urandom;
      r = $urandom_range(7, 0);
      rlat = (r < 5) ? r : (r < 7) ? $urandom_range(TO - 1, 0) : -1;
      e_acc = m_err(we, f3, a);
      if (e_acc) begin
        e_lat = 1; e_err = 1;
      end else if (rlat >= 0) begin
        e_lat = 2 + rlat; e_err = 0;
        if (!we) exp_rdata = m_load(f3, a, rd);
      end else begin
        e_lat = TO + 1; e_err = 1;
        if (!we) exp_rdata = '0;
      end
      run_access(we, f3, a, wd, rd, rlat);
      vectors++;
      if (o_lat != e_lat || o_err !== e_err || o_rdata !== exp_rdata || o_req == e_acc) begin
        miscompares++;
        $display("FAIL rand[%0d] we=%b f3=%b a=%h: got lat=%0d err=%b rdata=%h req=%b want %0d %b %h %b",
                 i, we, f3, a, o_lat, o_err, o_rdata, o_req, e_lat, e_err, exp_rdata, !e_acc);
      end
      vectors++;
      if (o_stall_bad || o_done_after !== 1'b0) begin
        miscompares++; $display("FAIL rand_hs[%0d] got stall_bad=%b done_after=%b want 0 0", i, o_stall_bad, o_done_after);
      end
      if (!e_acc) begin
        vectors++;
        if (o_addr !== {a[31:2], 2'b00} || o_be !== m_be(f3, a) || o_we !== we || o_unstable ||
            (we && o_wd !== m_wd(f3, wd))) begin
          miscompares++;
          $display("FAIL rand_port[%0d] got addr=%h be=%b we=%b wd=%h unstable=%b want %h %b %b %h 0",
                   i, o_addr, o_be, o_we, o_wd, o_unstable, {a[31:2], 2'b00}, m_be(f3, a), we, m_wd(f3, wd));
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lw();
    test_lb_lbu();
    test_sh();
    test_misaligned();
    test_timeout();
    test_rst_busy();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
